gate_op_scheduler: RTL and testbench
====================================

GATE_OP_SCHEDULER -- requirements
Module: gate_op_scheduler

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (range 2..32).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 NAND, 11 reserved.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same as REQ-004..007, for requester 1.
REQ-009 gate_a, gate_b  output  1  bit operands driven to the shared 1-bit AND/OR/NAND gate unit.
REQ-010 gate_and, gate_or, gate_nand  input  1  gate unit outputs, combinational from gate_a/gate_b.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_data  output  WIDTH  result word.
REQ-014 res_id  output  1  requester that issued the result.
REQ-015 res_err  output  1  result came from a reserved opcode.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 In IDLE, grant SHALL go to the only valid requester; if both are valid, grant SHALL go to the requester selected by the priority pointer.
REQ-019 reqN_ready SHALL be combinational: high only in IDLE, for the granted requester, while its valid is high; never both high.
REQ-020 On the edge where valid&&ready, a_reg, b_reg, op, and id SHALL be latched, bit index SHALL be set to 0, and state SHALL become RUN.
REQ-021 The priority pointer SHALL be set to the non-granted requester on every accept; it SHALL reset to 0.
REQ-022 In RUN, gate_a SHALL equal a_reg[idx] and gate_b SHALL equal b_reg[idx], LSB first.
REQ-023 In RUN, each edge SHALL store the selected gate output (per op) into result[idx] and increment idx.
REQ-024 When idx = WIDTH-1 is stored, state SHALL become DONE, so RUN lasts exactly WIDTH cycles.
REQ-025 gate_a and gate_b SHALL be 0 outside RUN.
REQ-026 For op 11, every result bit SHALL be 0, res_err SHALL be 1, and the WIDTH-cycle RUN timing SHALL be unchanged.
REQ-027 In DONE, res_valid SHALL be 1 and res_data/res_id/res_err SHALL be stable until res_valid&&res_ready.
REQ-028 On the edge where res_valid&&res_ready, state SHALL become IDLE and res_valid SHALL fall; res_data, res_id, and res_err SHALL hold their last values.
REQ-029 Latency: res_valid SHALL first be high WIDTH cycles after the accept edge; minimum issue interval SHALL be WIDTH+2 cycles.
REQ-030 No new request SHALL be accepted in RUN or DONE; the requester SHALL hold valid and operands stable until ready.
REQ-031 Operand changes on req* after the accept edge SHALL NOT affect the in-flight result.

Reset
REQ-032 While rst_n is low, the following SHALL be forced immediately, independent of clk: state IDLE, idx 0, pointer 0, res_valid 0, res_data 0, res_id 0, res_err 0, busy 0, gate_a/gate_b 0, both readies 0.
REQ-033 Reset asserted during RUN or DONE SHALL abandon the operation; no result for it SHALL ever appear.

Verification (WIDTH=8, real gate unit attached)
REQ-034 req0 AND A=0xF0 B=0x3C -> res_data=0x30, res_id=0, res_err=0, res_valid 8 cycles after accept.
REQ-035 Both valid from reset: req0 OR 0x0F/0xA0, req1 NAND 0xFF/0x0F -> req0 served first, 0xAF id 0; then req1 served, 0xF0 id 1.
REQ-036 res_ready held low 5 cycles in DONE -> res_valid and res_data stable, busy=1, req0_ready and req1_ready stay 0 despite valid.
REQ-037 rst_n pulsed low during RUN at idx=3 -> all outputs 0 at once; after release, pending req1 is granted fresh with correct result.
REQ-038 req1 op=11 A=0xFF B=0xFF -> res_data=0x00, res_err=1, 8-cycle latency.
REQ-039 req1 alone, three back-to-back ops -> each granted despite pointer, issue interval exactly 10 cycles with res_ready tied high.

Source files
------------

// File: rtl/gate_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : gate_op_scheduler
// Purpose : Two-requester scheduler for a shared 1-bit AND/OR/NAND gate unit.
//           An accepted WIDTH-bit operation is evaluated bit-serially, LSB
//           first, one bit per clock. The result is then held on a
//           valid/ready output port until the consumer accepts it.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           reqN_valid_i/_ready_o      - request handshake, N = 0/1
//           reqN_a_i, reqN_b_i         - operands (WIDTH bits)
//           reqN_op_i                  - 00 AND, 01 OR, 10 NAND, 11 reserved
//           gate_a_o, gate_b_o         - bit operands to the gate unit
//           gate_and_i/_or_i/_nand_i   - gate unit outputs (combinational)
//           res_valid_o/res_ready_i    - result handshake
//           res_data_o, res_id_o       - result word, issuing requester
//           res_err_o                  - result came from the reserved opcode
//           busy_o                     - scheduler not idle
// Revision: 1.0 - initial release
// ============================================================================
module gate_op_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [1:0]       req0_op_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [1:0]       req1_op_i,
    output logic             gate_a_o,
    output logic             gate_b_o,
    input  logic             gate_and_i,
    input  logic             gate_or_i,
    input  logic             gate_nand_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic             res_id_o,
    output logic             res_err_o,
    output logic             busy_o
);

    localparam int               IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ptr_q, ptr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             res_err_q, res_err_d;

    logic             grant1;
    logic             accept;
    logic             gate_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ptr_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            id_q       <= 1'b0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            id_q       <= id_d;
            acc_q      <= acc_d;
            res_data_q <= res_data_d;
            res_id_q   <= res_id_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        id_d       = id_q;
        acc_d      = acc_q;
        res_data_d = res_data_q;
        res_id_d   = res_id_q;
        res_err_d  = res_err_q;

        // Requester 1 wins when it is alone or when the pointer favours it.
        grant1 = req1_valid_i && (!req0_valid_i || ptr_q);

        // Readies are qualified with rst_n so they drop the instant reset
        // asserts, even though IDLE is the reset state.
        req0_ready_o = rst_n && (state_q == IDLE) && req0_valid_i && !grant1;
        req1_ready_o = rst_n && (state_q == IDLE) && grant1;
        accept       = req0_ready_o || req1_ready_o;

        gate_a_o = (state_q == RUN) ? a_q[idx_q] : 1'b0;
        gate_b_o = (state_q == RUN) ? b_q[idx_q] : 1'b0;

        // The reserved opcode still walks all bits but writes zeros, so its
        // timing matches the legal opcodes.
        case (op_q)
            2'b00:   gate_bit = gate_and_i;
            2'b01:   gate_bit = gate_or_i;
            2'b10:   gate_bit = gate_nand_i;
            default: gate_bit = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = grant1;
                    a_d     = grant1 ? req1_a_i  : req0_a_i;
                    b_d     = grant1 ? req1_b_i  : req0_b_i;
                    op_d    = grant1 ? req1_op_i : req0_op_i;
                    idx_d   = '0;
                    ptr_d   = !grant1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d[idx_q] = gate_bit;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // The visible result registers only change here, so they
                    // hold the previous result through IDLE and RUN.
                    idx_d      = '0;
                    res_data_d = acc_d;
                    res_id_d   = id_q;
                    res_err_d  = (op_q == 2'b11);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign res_data_o  = res_data_q;
    assign res_id_o    = res_id_q;
    assign res_err_o   = res_err_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_op_scheduler
// Purpose : Self-checking bench for gate_op_scheduler (WIDTH = 8) with a
//           real gate unit attached. Two requester drivers consume job
//           queues; a negedge monitor keeps a cycle-level reference model of
//           arbitration and timing, pushes expected results into a scoreboard
//           at each accept and compares them whenever a result is presented.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gate_op_scheduler;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]   req0_op, req1_op;
    logic         gate_a, gate_b, gate_and, gate_or, gate_nand;
    logic         res_valid, res_ready, res_id, res_err, busy;
    logic [W-1:0] res_data;

    always #5 clk = ~clk;

    assign gate_and  = gate_a & gate_b;
    assign gate_or   = gate_a | gate_b;
    assign gate_nand = ~(gate_a & gate_b);

    gate_op_scheduler #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_op_i    (req0_op),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_op_i    (req1_op),
        .gate_a_o     (gate_a),
        .gate_b_o     (gate_b),
        .gate_and_i   (gate_and),
        .gate_or_i    (gate_or),
        .gate_nand_i  (gate_nand),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_id_o     (res_id),
        .res_err_o    (res_err),
        .busy_o       (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } job_t;

    typedef struct {
        logic [W-1:0] data;
        logic         id;
        logic         err;
    } exp_t;

    job_t   q0[$];
    job_t   q1[$];
    exp_t   sb[$];
    int     acc_cyc[$];
    logic   drv_busy [2];

    int     n_vec  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    bit     rnd_rdy = 1'b0;

    // Reference model state: 0 idle, 1 evaluating, 2 result presented.
    int           mst = 0;
    int           rem = 0;
    logic         ptr = 1'b0;
    logic [W-1:0] cur_a, cur_b;
    logic [W-1:0] last_data = '0;
    logic         last_id = 1'b0, last_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return '0;
        endcase
    endfunction

    task automatic push_job(input bit k, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [1:0] op);
        job_t j;
        j.a = a; j.b = b; j.op = op;
        if (k) q1.push_back(j); else q0.push_back(j);
    endtask

    task automatic set_req(input bit k, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [1:0] op);
        if (k) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Requester: presents one job, holds it until ready, then scrambles the
    // operand lines so a late change would corrupt an in-flight result.
    task automatic run_driver(input bit k);
        job_t j;
        int   t;
        forever begin
            if ((k ? q1.size() : q0.size()) != 0) begin
                j = k ? q1.pop_front() : q0.pop_front();
                drv_busy[k] = 1'b1;
                set_req(k, 1'b1, j.a, j.b, j.op);
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(k ? req1_ready : req0_ready) && t < 2000);
                if (t >= 2000) begin
                    n_vec++; n_fail++;
                    $display("FAIL grant_timeout: requester %0d never granted", k);
                end
                @(posedge clk); #1;
                set_req(k, 1'b0, W'($urandom), W'($urandom), 2'($urandom));
                drv_busy[k] = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Monitor + reference model.
    initial begin
        logic g, has_g;
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mst = 0; rem = 0; ptr = 1'b0; sb.delete();
                last_data = '0; last_id = 1'b0; last_err = 1'b0;
            end else begin
                case (mst)
                    0: begin
                        has_g = req0_valid || req1_valid;
                        g     = (req0_valid && req1_valid) ? ptr : req1_valid;
                        check("ready0", 32'(req0_ready), 32'(has_g && !g));
                        check("ready1", 32'(req1_ready), 32'(has_g && g));
                        check("busy_idle", 32'(busy), 32'd0);
                        check("valid_idle", 32'(res_valid), 32'd0);
                        check("gate_idle", 32'({gate_a, gate_b}), 32'd0);
                        check("hold_data", 32'(res_data), 32'(last_data));
                        check("hold_id_err", 32'({res_id, res_err}), 32'({last_id, last_err}));
                        if (has_g) begin
                            cur_a  = g ? req1_a : req0_a;
                            cur_b  = g ? req1_b : req0_b;
                            e.data = ref_op(cur_a, cur_b, g ? req1_op : req0_op);
                            e.id   = g;
                            e.err  = ((g ? req1_op : req0_op) == 2'b11);
                            sb.push_back(e);
                            acc_cyc.push_back(cyc);
                            ptr = !g;
                            mst = 1;
                            rem = W;
                        end
                    end
                    1: begin
                        k = W - rem;
                        check("busy_run", 32'(busy), 32'd1);
                        check("ready_run", 32'({req0_ready, req1_ready}), 32'd0);
                        check("valid_run", 32'(res_valid), 32'd0);
                        check("gate_bits", 32'({gate_a, gate_b}), 32'({cur_a[k], cur_b[k]}));
                        check("hold_data_run", 32'(res_data), 32'(last_data));
                        rem--;
                        if (rem == 0) mst = 2;
                    end
                    default: begin
                        check("valid_done", 32'(res_valid), 32'd1);
                        check("busy_done", 32'(busy), 32'd1);
                        check("ready_done", 32'({req0_ready, req1_ready}), 32'd0);
                        check("gate_done", 32'({gate_a, gate_b}), 32'd0);
                        if (sb.size() == 0) begin
                            check("sb_empty", 32'd1, 32'd0);
                        end else begin
                            check("res_data", 32'(res_data), 32'(sb[0].data));
                            check("res_id", 32'(res_id), 32'(sb[0].id));
                            check("res_err", 32'(res_err), 32'(sb[0].err));
                            if (res_ready) begin
                                last_data = sb[0].data;
                                last_id   = sb[0].id;
                                last_err  = sb[0].err;
                                void'(sb.pop_front());
                                mst = 0;
                            end
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic reset_checks();
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_gate", 32'({gate_a, gate_b}), 32'd0);
        check("rst_valid_busy", 32'({res_valid, busy}), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_id_err", 32'({res_id, res_err}), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        reset_checks();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0 || drv_busy[0] || drv_busy[1] ||
                mst != 0 || sb.size() != 0) && t < 3000) begin
            @(posedge clk); #2;
            t++;
        end
        if (t >= 3000) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout: activity did not settle within %0d cycles", t);
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_model(input int st, input int r);
        int t = 0;
        do begin
            @(posedge clk); #2;
            t++;
        end while (!(mst == st && (r < 0 || rem == r)) && t < 500);
        if (t >= 500) begin
            n_vec++; n_fail++;
            $display("FAIL wait_timeout: state %0d not reached", st);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        drv_busy[0] = 1'b0;
        drv_busy[1] = 1'b0;
        rst_n     = 1'b0;
        res_ready = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, 2'b00);
        set_req(1'b1, 1'b0, '0, '0, 2'b00);
        fork
            run_driver(1'b0);
            run_driver(1'b1);
        join_none

        #1;
        reset_checks();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single AND
        push_job(1'b0, 8'hF0, 8'h3C, 2'b00);
        wait_drain();
        check("and_data", 32'(res_data), 32'h30);
        check("and_id_err", 32'({res_id, res_err}), 32'd0);

        // Both valid straight out of reset: requester 0 first
        @(posedge clk); #1;
        pulse_reset();
        push_job(1'b0, 8'h0F, 8'hA0, 2'b01);
        push_job(1'b1, 8'hFF, 8'h0F, 2'b10);
        wait_drain();
        check("pair_last_data", 32'(res_data), 32'hF0);
        check("pair_last_id", 32'(res_id), 32'd1);

        // Consumer back-pressure for 5 cycles while both requesters wait
        res_ready = 1'b0;
        push_job(1'b0, W'($urandom), W'($urandom), 2'b01);
        wait_model(2, -1);
        push_job(1'b0, W'($urandom), W'($urandom), 2'b00);
        push_job(1'b1, W'($urandom), W'($urandom), 2'b10);
        repeat (5) @(posedge clk);
        #1 res_ready = 1'b1;
        wait_drain();

        // Reset in the middle of an evaluation, requester 1 pending
        push_job(1'b0, W'($urandom), W'($urandom), 2'b00);
        wait_model(1, -1);
        push_job(1'b1, 8'h5A, 8'h33, 2'b01);
        wait_model(1, W - 3);
        pulse_reset();
        wait_drain();
        check("after_rst_data", 32'(res_data), 32'h7B);
        check("after_rst_id", 32'(res_id), 32'd1);

        // Reserved opcode
        push_job(1'b1, 8'hFF, 8'hFF, 2'b11);
        wait_drain();
        check("rsv_data", 32'(res_data), 32'h00);
        check("rsv_err", 32'(res_err), 32'd1);

        // Back-to-back issue from requester 1 alone
        n0 = acc_cyc.size();
        for (int i = 0; i < 3; i++) push_job(1'b1, W'($urandom), W'($urandom), 2'($urandom));
        wait_drain();
        if (acc_cyc.size() >= n0 + 3) begin
            check("interval_1", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'(W + 2));
            check("interval_2", 32'(acc_cyc[n0+2] - acc_cyc[n0+1]), 32'(W + 2));
        end else begin
            check("b2b_accepts", 32'(acc_cyc.size() - n0), 32'd3);
        end

        // Randomized traffic with random consumer back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push_job(1'($urandom), W'($urandom), W'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        wait_drain();
        rnd_rdy = 1'b0;
        #1 res_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
